// File: rtl/branch_pkg.sv
// Shared types for the branch predictor / redirect controller: FSM states,
// 2-bit bimodal counters and the in-flight branch queue entry.
package branch_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CTR_W = 2;

  typedef logic [CTR_W-1:0] ctr_t;

  localparam ctr_t CTR_RESET = 2'b01;

  typedef enum logic {
    RUN,
    RECOVER
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            pred;
    logic [XLEN-1:0] alt;
  } q_entry_t;

  // Saturating counter step toward the resolved outcome.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != 2'b11) r = c + CTR_W'(1);
    end else begin
      if (c != 2'b00) r = c - CTR_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_queue.sv
// Circular FIFO of in-flight predicted branches, oldest at the head.
// Clear wins over push and pop in the same cycle.
module branch_queue
  import branch_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_clear,
  input  q_entry_t                     i_data,
  output q_entry_t                     o_head,
  output logic [$clog2(QDEPTH+1)-1:0]  o_count,
  output logic                         o_full
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  q_entry_t         r_mem [QDEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;

  assign w_full    = (r_count == CNT_W'(QDEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push_ok = i_push & ~w_full;
  assign w_pop_ok  = i_pop & ~w_empty;

  // Pointer and occupancy bookkeeping; pointers wrap since QDEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + CNT_W'(1);
      else if (!w_push_ok && w_pop_ok) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;

endmodule

// File: rtl/branch_ctrl.sv
// Bimodal branch predictor at IF with an in-flight queue checked at EX;
// mispredicts produce a one-cycle redirect and a timed IF/ID flush.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES  = 16,
  parameter int unsigned QDEPTH       = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_imm,
  input  logic            if_is_branch,
  input  logic            if_is_jump,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic            ex_taken,
  output logic            pred_taken,
  output logic [XLEN-1:0] next_pc,
  output logic            q_full,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            err
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
  localparam int unsigned FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [BHT_ENTRIES-1:0][CTR_W-1:0] r_ctr;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [FC_W-1:0] r_fcnt;
  logic [FC_W-1:0] w_fcnt_nxt;
  logic            r_flush;
  logic            w_flush_nxt;
  logic            r_redirect;
  logic [XLEN-1:0] r_redirect_pc;
  logic            r_err;

  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_head_idx;
  logic             w_run;
  logic             w_pred;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_seq;
  logic             w_push;
  logic             w_ex;
  logic             w_pop;
  logic             w_ex_err;
  logic             w_mispred;
  logic             w_empty;
  logic             w_full;
  logic [CNT_W-1:0] w_count;
  q_entry_t         w_push_entry;
  q_entry_t         w_head;
  logic             w_unused_pc;

  assign w_run    = (r_state == RUN);
  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_target = if_pc + if_imm;
  assign w_seq    = if_pc + XLEN'(4);

  // Zero-latency prediction; suppressed entirely while recovering.
  assign w_pred     = w_run & if_valid & (if_is_jump | (if_is_branch & r_ctr[w_if_idx][1]));
  assign pred_taken = w_pred;
  assign next_pc    = w_pred ? w_target : w_seq;

  assign w_push = if_valid & if_is_branch & ~stall & ~w_full & w_run;
  assign w_push_entry.pc   = if_pc;
  assign w_push_entry.pred = w_pred;
  assign w_push_entry.alt  = w_pred ? w_seq : w_target;

  assign w_empty    = (w_count == '0);
  assign w_ex       = ex_valid & ~stall & w_run;
  assign w_pop      = w_ex & ~w_empty;
  assign w_ex_err   = w_ex & w_empty;
  assign w_mispred  = w_pop & (ex_taken != w_head.pred);
  assign w_head_idx = w_head.pc[IDX_W+1:2];

  assign w_unused_pc = ^{w_head.pc[XLEN-1:IDX_W+2], w_head.pc[1:0]};

  branch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_mispred),
    .i_data  (w_push_entry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  assign q_full = w_full;

  // Counter training on resolve; same-cycle prediction sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctr <= {BHT_ENTRIES{CTR_RESET}};
    end else if (w_pop) begin
      r_ctr[w_head_idx] <= ctr_next(r_ctr[w_head_idx], ex_taken);
    end
  end

  // Recovery sequencing: flush is held for FLUSH_CYCLES after a mispredict.
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_flush_nxt = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mispred) begin
          w_state_nxt = RECOVER;
          w_fcnt_nxt  = FC_W'(FLUSH_CYCLES - 1);
          w_flush_nxt = 1'b1;
        end
      end
      RECOVER: begin
        if (r_fcnt == '0) begin
          w_state_nxt = RUN;
        end else begin
          w_fcnt_nxt  = r_fcnt - FC_W'(1);
          w_flush_nxt = 1'b1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_fcnt  <= '0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_flush <= w_flush_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_err         <= 1'b0;
    end else begin
      r_redirect <= w_mispred;
      if (w_mispred) r_redirect_pc <= w_head.alt;
      if (w_ex_err)  r_err <= 1'b1;
    end
  end

  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;
  assign flush       = r_flush;
  assign err         = r_err;

endmodule
